// File: rtl/mem_access_unit.sv
// Load/store initiator between the datapath and a word-addressed RAM with
// combinational read and synchronous full-word write; sub-word stores use read-modify-write.
module mem_access_unit #(
  parameter int unsigned MEM_WORDS  = 64,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_op,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_err,
  output logic [31:0]           mem_address,
  output logic                  mem_read_en,
  output logic                  mem_write_en,
  output logic [DATA_WIDTH-1:0] mem_data_write,
  input  logic [DATA_WIDTH-1:0] mem_data_out
);

  localparam logic [2:0] OpLw  = 3'd0;
  localparam logic [2:0] OpLh  = 3'd1;
  localparam logic [2:0] OpLhu = 3'd2;
  localparam logic [2:0] OpLb  = 3'd3;
  localparam logic [2:0] OpLbu = 3'd4;
  localparam logic [2:0] OpSw  = 3'd5;
  localparam logic [2:0] OpSh  = 3'd6;
  localparam logic [2:0] OpSb  = 3'd7;

  localparam logic [31:0] MemWords32 = 32'(MEM_WORDS);

  typedef enum logic [1:0] {StIdle, StRd, StWr, StRsp} state_e;

  state_e      state;
  logic [2:0]  op_q;
  logic [1:0]  lane_q;
  logic [15:0] wdata_q;

  function automatic logic [31:0] load_extract(logic [2:0] op, logic [1:0] lane,
                                               logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    case (op)
      OpLh:    return {{16{h[15]}}, h};
      OpLhu:   return {16'h0000, h};
      OpLb:    return {{24{b[7]}}, b};
      OpLbu:   return {24'h000000, b};
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] lane_merge(logic [2:0] op, logic [1:0] lane,
                                             logic [31:0] word, logic [15:0] wdata);
    logic [31:0] r;
    r = word;
    if (op == OpSb) r[{lane, 3'b000} +: 8] = wdata[7:0];
    else            r[{lane[1], 4'b0000} +: 16] = wdata;
    return r;
  endfunction

  logic is_word, is_half, req_err;

  always_comb begin
    is_word = (req_op == OpLw) || (req_op == OpSw);
    is_half = (req_op == OpLh) || (req_op == OpLhu) || (req_op == OpSh);
    req_err = (is_word && (req_addr[1:0] != 2'b00)) || (is_half && req_addr[0]) ||
              ({2'b00, req_addr[31:2]} >= MemWords32);
  end

  assign req_ready = (state == StIdle);

  // The RAM word is merged with the store lane as it is read, so the merged value
  // lands directly in mem_data_write and no separate word buffer is kept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= StIdle;
      op_q           <= '0;
      lane_q         <= '0;
      wdata_q        <= '0;
      rsp_valid      <= 1'b0;
      rsp_data       <= '0;
      rsp_err        <= 1'b0;
      mem_address    <= '0;
      mem_read_en    <= 1'b0;
      mem_write_en   <= 1'b0;
      mem_data_write <= '0;
    end else begin
      mem_read_en  <= 1'b0;
      mem_write_en <= 1'b0;
      case (state)
        StIdle: begin
          if (req_valid) begin
            op_q    <= req_op;
            lane_q  <= req_addr[1:0];
            wdata_q <= req_wdata[15:0];
            if (req_err) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_data  <= '0;
              state     <= StRsp;
            end else begin
              mem_address <= {req_addr[31:2], 2'b00};
              if (req_op == OpSw) begin
                mem_write_en   <= 1'b1;
                mem_data_write <= req_wdata;
                state          <= StWr;
              end else begin
                mem_read_en <= 1'b1;
                state       <= StRd;
              end
            end
          end
        end
        StRd: begin
          if ((op_q == OpSb) || (op_q == OpSh)) begin
            mem_write_en   <= 1'b1;
            mem_data_write <= lane_merge(op_q, lane_q, mem_data_out, wdata_q);
            state          <= StWr;
          end else begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_data  <= load_extract(op_q, lane_q, mem_data_out);
            state     <= StRsp;
          end
        end
        StWr: begin
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_data  <= '0;
          state     <= StRsp;
        end
        StRsp: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: table of requests with a response scoreboard and a small
// RAM model, plus hand-written backpressure and mid-operation reset sequences.
module tb_mem_access_unit;

  localparam logic [2:0] LW = 3'd0, LH = 3'd1, LHU = 3'd2, LB = 3'd3, LBU = 3'd4;
  localparam logic [2:0] SW = 3'd5, SH = 3'd6, SB = 3'd7;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
  logic [2:0]  req_op;
  logic [31:0] req_addr, req_wdata, rsp_data;
  logic [31:0] mem_address, mem_data_write, mem_data_out;
  logic        mem_read_en, mem_write_en;

  mem_access_unit #(.MEM_WORDS(64), .DATA_WIDTH(32)) dut (
    .clk(clk), .reset(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .mem_address(mem_address), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .mem_data_write(mem_data_write), .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  // RAM model: combinational read, synchronous write, plus a bench-only load port.
  logic [31:0] ram [64];
  logic        ld_en = 1'b0;
  logic [5:0]  ld_idx = '0;
  logic [31:0] ld_val = '0;
  assign mem_data_out = ram[mem_address[7:2]];
  always @(posedge clk) begin
    if (ld_en) ram[ld_idx] <= ld_val;
    else if (mem_write_en) ram[mem_address[7:2]] <= mem_data_write;
  end

  int          rd_cnt = 0, wr_cnt = 0;
  logic [31:0] last_addr = '0, last_wdata = '0;
  always @(posedge clk) begin
    if (mem_read_en) begin
      rd_cnt    <= rd_cnt + 1;
      last_addr <= mem_address;
    end
    if (mem_write_en) begin
      wr_cnt     <= wr_cnt + 1;
      last_addr  <= mem_address;
      last_wdata <= mem_data_write;
    end
  end

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] data;
    logic        err;
    int          lat;
    int          rd;
    int          wr;
    logic [31:0] mdw;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   total = 0, bad = 0;
  int   rd_snap, wr_snap;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic wait_rsp();
    int   lat;
    vec_t e;
    lat = 1;
    @(negedge clk);
    while (!rsp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    check("latency", 32'(lat), 32'(e.lat));
    check("rsp_data", rsp_data, e.data);
    check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
    check("read_en_cycles", 32'(rd_cnt - rd_snap), 32'(e.rd));
    check("write_en_cycles", 32'(wr_cnt - wr_snap), 32'(e.wr));
    if (e.rd + e.wr > 0) check("mem_address", last_addr, {e.addr[31:2], 2'b00});
    if (e.wr > 0) check("mem_data_write", last_wdata, e.mdw);
  endtask

  task automatic drive(vec_t v);
    req_valid = 1'b1;
    req_op    = v.op;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    sb.push_back(v);
    rd_snap = rd_cnt;
    wr_snap = wr_cnt;
  endtask

  task automatic do_req(vec_t v);
    @(negedge clk);
    check("req_ready_idle", {31'd0, req_ready}, 32'd1);
    drive(v);
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_rsp();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b1;

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ld_en  = 1'b1;
      ld_idx = (i == 3) ? 6'd63 : 6'(i);
      ld_val = (i == 0) ? 32'h7FFF0001 : (i == 1) ? 32'h11223344 :
               (i == 2) ? 32'h00000005 : 32'hA5A5A5A5;
    end
    @(negedge clk);
    ld_en = 1'b0;

    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    check("rst_read_en", {31'd0, mem_read_en}, 32'd0);
    check("rst_write_en", {31'd0, mem_write_en}, 32'd0);
    check("rst_mem_address", mem_address, 32'd0);
    check("rst_mem_data_write", mem_data_write, 32'd0);
    rst_n = 1'b1;

    //                op   addr          wdata         data          err lat rd wr mdw
    vecs.push_back('{LW,  32'h4,        32'h0,        32'h11223344, 0, 2, 1, 0, 32'h0});
    vecs.push_back('{SW,  32'h4,        32'h80223344, 32'h0,        0, 2, 0, 1, 32'h80223344});
    vecs.push_back('{LB,  32'h7,        32'h0,        32'hFFFFFF80, 0, 2, 1, 0, 32'h0});
    vecs.push_back('{LBU, 32'h7,        32'h0,        32'h00000080, 0, 2, 1, 0, 32'h0});
    vecs.push_back('{LH,  32'h6,        32'h0,        32'hFFFF8022, 0, 2, 1, 0, 32'h0});
    vecs.push_back('{LHU, 32'h4,        32'h0,        32'h00003344, 0, 2, 1, 0, 32'h0});
    vecs.push_back('{LB,  32'h4,        32'h0,        32'h00000044, 0, 2, 1, 0, 32'h0});
    vecs.push_back('{LB,  32'h5,        32'h0,        32'h00000033, 0, 2, 1, 0, 32'h0});
    vecs.push_back('{SW,  32'h4,        32'h11223344, 32'h0,        0, 2, 0, 1, 32'h11223344});
    vecs.push_back('{SB,  32'h5,        32'h000000AB, 32'h0,        0, 3, 1, 1, 32'h1122AB44});
    vecs.push_back('{LW,  32'h4,        32'h0,        32'h1122AB44, 0, 2, 1, 0, 32'h0});
    vecs.push_back('{SH,  32'h6,        32'h1234CAFE, 32'h0,        0, 3, 1, 1, 32'hCAFEAB44});
    vecs.push_back('{LW,  32'h4,        32'h0,        32'hCAFEAB44, 0, 2, 1, 0, 32'h0});
    vecs.push_back('{LH,  32'h2,        32'h0,        32'h00007FFF, 0, 2, 1, 0, 32'h0});
    vecs.push_back('{LH,  32'h0,        32'h0,        32'h00000001, 0, 2, 1, 0, 32'h0});
    vecs.push_back('{LW,  32'hFC,       32'h0,        32'hA5A5A5A5, 0, 2, 1, 0, 32'h0});
    vecs.push_back('{LW,  32'h6,        32'h0,        32'h0,        1, 1, 0, 0, 32'h0});
    vecs.push_back('{SH,  32'h3,        32'h0,        32'h0,        1, 1, 0, 0, 32'h0});
    vecs.push_back('{LW,  32'h100,      32'h0,        32'h0,        1, 1, 0, 0, 32'h0});
    vecs.push_back('{LHU, 32'h1,        32'h0,        32'h0,        1, 1, 0, 0, 32'h0});
    vecs.push_back('{SB,  32'h103,      32'h77,       32'h0,        1, 1, 0, 0, 32'h0});
    vecs.push_back('{SW,  32'hFFFFFFFC, 32'h12345678, 32'h0,        1, 1, 0, 0, 32'h0});
    vecs.push_back('{SB,  32'h0,        32'h0000005A, 32'h0,        0, 3, 1, 1, 32'h7FFF005A});
    vecs.push_back('{LBU, 32'h0,        32'h0,        32'h0000005A, 0, 2, 1, 0, 32'h0});

    foreach (vecs[i]) do_req(vecs[i]);
    check("ram_word1", ram[1], 32'hCAFEAB44);
    check("ram_word2", ram[2], 32'h00000005);

    // Backpressure: response held, a second request waits until IDLE.
    @(negedge clk);
    rsp_ready = 1'b0;
    drive('{LW, 32'h4, 32'h0, 32'hCAFEAB44, 1'b0, 2, 1, 0, 32'h0});
    @(posedge clk);
    #1 req_op = LW; req_addr = 32'hFC; req_wdata = '0;
    wait_rsp();
    rd_snap = rd_cnt;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("bp_rsp_data", rsp_data, 32'hCAFEAB44);
      check("bp_req_ready", {31'd0, req_ready}, 32'd0);
    end
    check("bp_ignored_req", 32'(rd_cnt - rd_snap), 32'd0);
    rsp_ready = 1'b1;
    sb.push_back('{LW, 32'hFC, 32'h0, 32'hA5A5A5A5, 1'b0, 2, 1, 0, 32'h0});
    wr_snap = wr_cnt;
    @(posedge clk);
    @(negedge clk);
    check("bp_idle_ready", {31'd0, req_ready}, 32'd1);
    check("bp_valid_dropped", {31'd0, rsp_valid}, 32'd0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_rsp();

    // Reset asserted during the write cycle of an SW.
    @(negedge clk);
    req_valid = 1'b1; req_op = SW; req_addr = 32'h8; req_wdata = 32'hDEADBEEF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    check("rm_write_en_before", {31'd0, mem_write_en}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rm_write_en_cleared", {31'd0, mem_write_en}, 32'd0);
    check("rm_req_ready", {31'd0, req_ready}, 32'd1);
    check("rm_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rm_rsp_data", rsp_data, 32'd0);
    check("rm_mem_address", mem_address, 32'd0);
    check("rm_mem_data_write", mem_data_write, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("rm_ram_word2", ram[2], 32'h00000005);
    rst_n = 1'b1;
    do_req('{LW, 32'h8, 32'h0, 32'h00000005, 1'b0, 2, 1, 0, 32'h0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
